// File: rtl/keypad_password_entry.sv
// Keypad front-end: synchronizes and debounces raw buttons, buffers four hex digits,
// and sequences a clean enter pulse into the password authenticator.
module keypad_password_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ENTER_PULSE     = 3,
    parameter int RESULT_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_raw,
    input  logic [3:0]  key_code,
    input  logic        enter_raw,
    input  logic        clear_raw,
    input  logic        led_success,
    input  logic        led_fail,
    input  logic        led_locked,
    output logic [15:0] password_out,
    output logic        enter_btn,
    output logic [2:0]  digit_count,
    output logic        busy,
    output logic        short_entry,
    output logic        timeout_err
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(ENTER_PULSE + 1);
    localparam int TW = $clog2(RESULT_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_SUBMIT, S_WAIT, S_LOCKED} state_t;

    // Button bit order: 0 = digit key, 1 = enter, 2 = clear
    logic [2:0] raw_meta_reg, raw_sync_reg;
    logic [3:0] code_meta_reg, code_sync_reg;
    logic [2:0] btn_event;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_meta_reg  <= '0;
            raw_sync_reg  <= '0;
            code_meta_reg <= '0;
            code_sync_reg <= '0;
        end else begin
            raw_meta_reg  <= {clear_raw, enter_raw, key_raw};
            raw_sync_reg  <= raw_meta_reg;
            code_meta_reg <= key_code;
            code_sync_reg <= code_meta_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_debounce
            logic [DW-1:0] cnt_reg;
            logic          level_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end else if (raw_sync_reg[gi] != level_reg) begin
                    if (cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
                        level_reg <= raw_sync_reg[gi];
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + DW'(1);
                    end
                end else begin
                    cnt_reg <= '0;
                end
            end

            // Fires on the cycle the debounced level is about to rise
            assign btn_event[gi] = raw_sync_reg[gi] && !level_reg &&
                                   (cnt_reg == DW'(DEBOUNCE_CYCLES - 1));
        end
    endgenerate

    state_t        state_reg;
    logic [15:0]   buf_reg;
    logic [2:0]    count_reg;
    logic          enter_reg;
    logic          busy_reg;
    logic          short_reg;
    logic          tmo_reg;
    logic [PW-1:0] pulse_cnt_reg;
    logic [TW-1:0] wait_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            buf_reg       <= '0;
            count_reg     <= '0;
            enter_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            short_reg     <= 1'b0;
            tmo_reg       <= 1'b0;
            pulse_cnt_reg <= '0;
            wait_cnt_reg  <= '0;
        end else begin
            short_reg <= 1'b0;
            tmo_reg   <= 1'b0;
            if (led_locked) begin
                state_reg <= S_LOCKED;
                enter_reg <= 1'b0;
                busy_reg  <= 1'b1;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (btn_event[2]) begin
                            buf_reg   <= '0;
                            count_reg <= '0;
                        end else if (btn_event[1]) begin
                            if (count_reg == 3'd4) begin
                                state_reg     <= S_SUBMIT;
                                enter_reg     <= 1'b1;
                                busy_reg      <= 1'b1;
                                pulse_cnt_reg <= '0;
                            end else begin
                                short_reg <= 1'b1;
                            end
                        end else if (btn_event[0] && count_reg != 3'd4) begin
                            buf_reg   <= {buf_reg[11:0], code_sync_reg};
                            count_reg <= count_reg + 3'd1;
                        end
                    end
                    S_SUBMIT: begin
                        if (pulse_cnt_reg == PW'(ENTER_PULSE - 1)) begin
                            enter_reg    <= 1'b0;
                            state_reg    <= S_WAIT;
                            wait_cnt_reg <= '0;
                        end else begin
                            pulse_cnt_reg <= pulse_cnt_reg + PW'(1);
                        end
                    end
                    S_WAIT: begin
                        // Success and fail are handled identically here
                        if (led_success || led_fail) begin
                            buf_reg   <= '0;
                            count_reg <= '0;
                            busy_reg  <= 1'b0;
                            state_reg <= S_IDLE;
                        end else if (wait_cnt_reg == TW'(RESULT_TIMEOUT - 1)) begin
                            tmo_reg   <= 1'b1;
                            buf_reg   <= '0;
                            count_reg <= '0;
                            busy_reg  <= 1'b0;
                            state_reg <= S_IDLE;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + TW'(1);
                        end
                    end
                    S_LOCKED: begin
                        buf_reg   <= '0;
                        count_reg <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    // Lockout kills the enter pulse in the same cycle rather than a cycle later
    assign enter_btn    = enter_reg && !led_locked;
    assign password_out = buf_reg;
    assign digit_count  = count_reg;
    assign busy         = busy_reg;
    assign short_entry  = short_reg;
    assign timeout_err  = tmo_reg;
endmodule

// File: tb/tb_keypad_password_entry.sv
// Directed + randomized bench for keypad_password_entry with a digit-buffer model.
module tb_keypad_password_entry;
    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_raw = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        enter_raw = 1'b0;
    logic        clear_raw = 1'b0;
    logic        led_success = 1'b0;
    logic        led_fail = 1'b0;
    logic        led_locked = 1'b0;
    logic [15:0] password_out;
    logic        enter_btn;
    logic [2:0]  digit_count;
    logic        busy;
    logic        short_entry;
    logic        timeout_err;

    keypad_password_entry #(
        .DEBOUNCE_CYCLES(DEB), .ENTER_PULSE(3), .RESULT_TIMEOUT(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .key_code(key_code),
        .enter_raw(enter_raw), .clear_raw(clear_raw), .led_success(led_success),
        .led_fail(led_fail), .led_locked(led_locked), .password_out(password_out),
        .enter_btn(enter_btn), .digit_count(digit_count), .busy(busy),
        .short_entry(short_entry), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int enter_hi, short_seen, tmo_seen, fall_cyc, tmo_cyc;
    logic prev_en = 1'b0;
    logic [15:0] pw_m = 16'h0;
    int cnt_m = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_acc();
        enter_hi = 0; short_seen = 0; tmo_seen = 0; fall_cyc = -1; tmo_cyc = -1;
    endtask

    // One clock; outputs sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (enter_btn === 1'b1) begin
            if (!prev_en) check("pw_at_enter", password_out, pw_m);
            enter_hi++;
        end
        if (prev_en && enter_btn !== 1'b1) fall_cyc = cyc;
        if (timeout_err === 1'b1) begin
            tmo_seen++;
            if (tmo_cyc < 0) tmo_cyc = cyc;
        end
        if (short_entry === 1'b1) short_seen++;
        prev_en = (enter_btn === 1'b1);
    endtask

    task automatic set_raw(input int which, input logic v);
        case (which)
            0: key_raw = v;
            1: enter_raw = v;
            default: clear_raw = v;
        endcase
    endtask

    // Bouncy press and release of one button (0 key, 1 enter, 2 clear)
    task automatic press(input int which, input logic [3:0] code);
        if (which == 0) key_code = code;
        repeat ($urandom_range(0, 3)) begin
            set_raw(which, 1'b1); repeat ($urandom_range(1, 2)) tick();
            set_raw(which, 1'b0); repeat ($urandom_range(1, 2)) tick();
        end
        set_raw(which, 1'b1); repeat (DEB + 4) tick();
        set_raw(which, 1'b0); repeat ($urandom_range(1, 2)) tick();
        set_raw(which, 1'b1); tick();
        set_raw(which, 1'b0); repeat (DEB + 4) tick();
    endtask

    task automatic digit(input logic [3:0] c);
        press(0, c);
        if (cnt_m < 4) begin
            pw_m = {pw_m[11:0], c};
            cnt_m++;
        end
        check("digit_count", digit_count, cnt_m);
        check("password", password_out, pw_m);
    endtask

    task automatic do_clear();
        press(2, 4'h0);
        pw_m = 16'h0; cnt_m = 0;
        check("clear_count", digit_count, 0);
        check("clear_pw", password_out, 16'h0);
    endtask

    task automatic wait_enter();
        int k = 0;
        while (enter_btn !== 1'b1 && k < 40) begin
            tick(); k++;
        end
        check("enter_seen", enter_btn, 1);
    endtask

    initial begin
        clr_acc();
        repeat (3) tick();
        check("rst_pw", password_out, 0);
        check("rst_count", digit_count, 0);
        check("rst_enter", enter_btn, 0);
        check("rst_busy", busy, 0);
        check("rst_short", short_entry, 0);
        check("rst_tmo", timeout_err, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 1,2,3,4 then enter, answered with success
        digit(4'h1); digit(4'h2); digit(4'h3); digit(4'h4);
        clr_acc();
        press(1, 4'h0);
        check("t1_enter_cycles", enter_hi, 3);
        check("t1_busy", busy, 1);
        check("t1_pw_frozen", password_out, 16'h1234);
        led_success = 1'b1; tick(); led_success = 1'b0; tick();
        pw_m = 16'h0; cnt_m = 0;
        check("t1_count", digit_count, 0);
        check("t1_pw", password_out, 0);
        check("t1_idle", busy, 0);

        // Short glitch, then A..E with E dropped
        key_code = 4'h7; key_raw = 1'b1; repeat (DEB - 2) tick();
        key_raw = 1'b0; repeat (DEB + 4) tick();
        check("glitch_count", digit_count, 0);
        digit(4'hA); digit(4'hB); digit(4'hC); digit(4'hD); digit(4'hE);
        check("abcd", password_out, 16'hABCD);
        do_clear();

        // Short entry
        digit(4'h1); digit(4'h2);
        clr_acc();
        press(1, 4'h0);
        check("short_pulse", short_seen, 1);
        check("short_no_enter", enter_hi, 0);
        check("short_pw", password_out, 16'h0012);
        do_clear();

        // Timeout
        repeat (4) digit(4'hF);
        clr_acc();
        press(1, 4'h0);
        begin
            int k = 0;
            while (tmo_seen == 0 && k < 120) begin
                tick(); k++;
            end
        end
        repeat (3) tick();
        check("tmo_once", tmo_seen, 1);
        check("tmo_delay", tmo_cyc - fall_cyc, 64);
        check("tmo_enter_cycles", enter_hi, 3);
        pw_m = 16'h0; cnt_m = 0;
        check("tmo_pw", password_out, 0);
        check("tmo_count", digit_count, 0);
        check("tmo_busy", busy, 0);

        // Three failed submissions, then lockout mid-submit
        for (int i = 0; i < 3; i++) begin
            repeat (4) digit(4'hF);
            clr_acc();
            press(1, 4'h0);
            check("fail_enter_cycles", enter_hi, 3);
            led_fail = 1'b1; led_success = (i == 2); tick();
            led_fail = 1'b0; led_success = 1'b0; tick();
            pw_m = 16'h0; cnt_m = 0;
            check("fail_count", digit_count, 0);
            check("fail_pw", password_out, 0);
        end
        repeat (4) digit(4'hF);
        clr_acc();
        enter_raw = 1'b1;
        wait_enter();
        led_locked = 1'b1;
        #1;
        check("lock_enter_now", enter_btn, 0);
        tick();
        check("lock_enter", enter_btn, 0);
        check("lock_busy", busy, 1);
        press(0, 4'h5);
        check("lock_count", digit_count, 4);
        check("lock_pw", password_out, 16'hFFFF);
        enter_raw = 1'b0; repeat (DEB + 4) tick();
        led_locked = 1'b0; repeat (3) tick();
        pw_m = 16'h0; cnt_m = 0;
        check("unlock_busy", busy, 0);
        check("unlock_pw", password_out, 0);
        check("unlock_count", digit_count, 0);
        check("lock_enter_cycles", enter_hi, 1);

        // Randomized digit / clear / short-enter mix
        for (int i = 0; i < 14; i++) begin
            int r = $urandom_range(0, 9);
            if (r < 7) digit(4'($urandom_range(0, 15)));
            else if (r == 7 || cnt_m == 4) do_clear();
            else begin
                clr_acc();
                press(1, 4'h0);
                check("rnd_short", short_seen, 1);
                check("rnd_no_enter", enter_hi, 0);
                check("rnd_pw", password_out, pw_m);
            end
        end

        // Clear and enter together with four digits buffered
        while (cnt_m < 4) digit(4'($urandom_range(0, 15)));
        clr_acc();
        clear_raw = 1'b1; enter_raw = 1'b1; repeat (DEB + 6) tick();
        clear_raw = 1'b0; enter_raw = 1'b0; repeat (DEB + 4) tick();
        pw_m = 16'h0; cnt_m = 0;
        check("both_no_enter", enter_hi, 0);
        check("both_no_short", short_seen, 0);
        check("both_busy", busy, 0);
        check("both_pw", password_out, 0);
        check("both_count", digit_count, 0);

        // Asynchronous reset during SUBMIT
        repeat (4) digit(4'($urandom_range(0, 15)));
        clr_acc();
        enter_raw = 1'b1;
        wait_enter();
        rst_n = 1'b0;
        #1;
        check("arst_enter", enter_btn, 0);
        check("arst_pw", password_out, 0);
        check("arst_count", digit_count, 0);
        check("arst_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
